vote_result_display: RTL and testbench

//  Board-side reader of the voting state machine's outputs (state, winner, vote count, LED enable).

---
 rtl/vote_disp_pkg.sv | 73 +++++++
 rtl/bin2bcd_seq.sv | 80 ++++++++
 rtl/vote_result_display.sv | 249 ++++++++++++++++++++++++
 tb/tb_vote_result_display.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/vote_disp_pkg.sv
// ---------------------------------------------------------------------------
// vote_disp_pkg
// Shared definitions for the voting result display:
//   - voting FSM state encodings (identical to the voting FSM itself)
//   - winner codes
//   - active-low 7-segment glyphs, bit order {CG,CF,CE,CD,CC,CB,CA}
//   - state encoding of the sequential binary-to-BCD converter
//   - digitGlyph(): BCD digit to glyph lookup
// No ports (package).
// ---------------------------------------------------------------------------
package vote_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_OPEN   = 2'b01,
        ST_CLOSED = 2'b10,
        ST_WIN    = 2'b11
    } vote_state_e;

    typedef enum logic {
        BCD_IDLE  = 1'b0,
        BCD_SHIFT = 1'b1
    } bcd_state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_C1   = 2'b01;
    localparam logic [1:0] WIN_C2   = 2'b10;
    localparam logic [1:0] WIN_C3   = 2'b11;

    // A segment is lit when its bit is 0.
    localparam logic [6:0] G_0     = 7'h40;
    localparam logic [6:0] G_1     = 7'h79;
    localparam logic [6:0] G_2     = 7'h24;
    localparam logic [6:0] G_3     = 7'h30;
    localparam logic [6:0] G_4     = 7'h19;
    localparam logic [6:0] G_5     = 7'h12;
    localparam logic [6:0] G_6     = 7'h02;
    localparam logic [6:0] G_7     = 7'h78;
    localparam logic [6:0] G_8     = 7'h00;
    localparam logic [6:0] G_9     = 7'h10;
    localparam logic [6:0] G_DASH  = 7'h3F;
    localparam logic [6:0] G_BLANK = 7'h7F;
    localparam logic [6:0] G_O     = 7'h40;
    localparam logic [6:0] G_P     = 7'h0C;
    localparam logic [6:0] G_E     = 7'h06;
    localparam logic [6:0] G_N     = 7'h2B;
    localparam logic [6:0] G_C     = 7'h46;
    localparam logic [6:0] G_L     = 7'h47;
    localparam logic [6:0] G_S     = 7'h12;
    localparam logic [6:0] G_D     = 7'h21;
    localparam logic [6:0] G_T     = 7'h07;
    localparam logic [6:0] G_I     = 7'h79;

    // Codes above 9 never occur from the converter; show them blank.
    function automatic logic [6:0] digitGlyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = G_0;
            4'd1:    g = G_1;
            4'd2:    g = G_2;
            4'd3:    g = G_3;
            4'd4:    g = G_4;
            4'd5:    g = G_5;
            4'd6:    g = G_6;
            4'd7:    g = G_7;
            4'd8:    g = G_8;
            4'd9:    g = G_9;
            default: g = G_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter, 9-bit binary to three BCD digits.
// One load cycle followed by nine shift cycles; done is a one-cycle pulse
// that appears 10 cycles after start, while bcd holds the result.
// Ports:
//   clk    in   1   clock
//   reset  in   1   synchronous, active-high
//   start  in   1   load bin and begin converting (restarts if busy)
//   bin    in   9   binary value 0..511
//   done   out  1   result valid pulse
//   bcd    out  12  {hundreds, tens, ones}
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import vote_disp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [8:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);

    bcd_state_e  state_q, state_d;
    logic [3:0]  shiftCnt_q, shiftCnt_d;
    logic [20:0] shiftReg_q, shiftReg_d;
    logic        done_q, done_d;

    // One double-dabble step: correct any BCD nibble >= 5, then shift left.
    function automatic logic [20:0] dabble(input logic [20:0] s);
        logic [20:0] t;
        t = s;
        for (int j = 0; j < 3; j++) begin
            if (t[9+4*j +: 4] >= 4'd5) begin
                t[9+4*j +: 4] = t[9+4*j +: 4] + 4'd3;
            end
        end
        return {t[19:0], 1'b0};
    endfunction

    // Load on start, then shift nine times; the last shift raises done.
    always_comb begin
        state_d    = state_q;
        shiftCnt_d = shiftCnt_q;
        shiftReg_d = shiftReg_q;
        done_d     = 1'b0;
        if (start) begin
            shiftReg_d = {12'd0, bin};
            shiftCnt_d = 4'd9;
            state_d    = BCD_SHIFT;
        end else if (state_q == BCD_SHIFT) begin
            shiftReg_d = dabble(shiftReg_q);
            shiftCnt_d = shiftCnt_q - 4'd1;
            if (shiftCnt_q == 4'd1) begin
                done_d  = 1'b1;
                state_d = BCD_IDLE;
            end
        end
    end

    // Converter state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BCD_IDLE;
            shiftCnt_q <= 4'd0;
            shiftReg_q <= 21'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftCnt_q <= shiftCnt_d;
            shiftReg_q <= shiftReg_d;
            done_q     <= done_d;
        end
    end

    assign done = done_q;
    assign bcd  = shiftReg_q[20:9];

endmodule

// File: rtl/vote_result_display.sv
// ---------------------------------------------------------------------------
// vote_result_display
// Shows the voting FSM outputs on the Nexys A7 8-digit multiplexed display
// and the 16 LEDs. Inputs arrive from the slow voting clock domain and are
// synchronized; a frame-aligned snapshot is converted to BCD and committed
// atomically so a frame never shows mixed values.
// Optional feature macro: VOTE_DISP_WINNER_LED_EN (winner shown on LEDs in
// DISPLAY_WIN; a tie flashes led[3:0]).
// Parameters:
//   REFRESH_DIV  clk cycles per digit slot (>= 16)
//   FLASH_DIV    clk cycles per LED flash half-period
// Ports:
//   clk          in   1   board clock
//   reset        in   1   synchronous, active-high
//   the_state    in   2   voting FSM state
//   the_winner   in   2   00 tie/none, 01..11 candidate 1..3
//   vote_count   in   9   total votes
//   enable_leds  in   1   high while voting is open
//   an           out  8   digit anodes, active-low, an[0] rightmost
//   seg          out  7   cathodes CA..CG on seg[0]..seg[6], active-low
//   dp           out  1   decimal point, always off
//   led          out  16  board LEDs, active-high
// ---------------------------------------------------------------------------
module vote_result_display
    import vote_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000,
    parameter int FLASH_DIV   = 25_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  the_state,
    input  logic [1:0]  the_winner,
    input  logic [8:0]  vote_count,
    input  logic        enable_leds,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [15:0] led
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int FW = $clog2(FLASH_DIV);

    logic [13:0]   sync1_q, sync2_q;
    vote_state_e   syncState;
    logic [1:0]    syncWinner;
    logic [8:0]    syncCount;
    logic          syncEn;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    digitIdx_q, digitIdx_d;
    logic          tick, frameStart;

    vote_state_e   snapState_q, dispState_q;
    logic [1:0]    snapWinner_q, dispWinner_q;
    logic [11:0]   dispBcd_q;
    logic          bcdDone;
    logic [11:0]   bcdValue;

    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic [FW-1:0] flashCnt_q, flashCnt_d;
    logic          phase_q, phase_d;
    logic          armS1, armS2;

    // Two-flop synchronizer on every input bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 14'd0;
            sync2_q <= 14'd0;
        end else begin
            sync1_q <= {the_state, the_winner, vote_count, enable_leds};
            sync2_q <= sync1_q;
        end
    end

    assign syncState  = vote_state_e'(sync2_q[13:12]);
    assign syncWinner = sync2_q[11:10];
    assign syncCount  = sync2_q[9:1];
    assign syncEn     = sync2_q[0];

    // Digit slot timing: the prescaler wrap advances the digit index, and
    // the wrap of the index from 7 back to 0 marks the start of a frame.
    assign tick       = (presc_q == PW'(REFRESH_DIV - 1));
    assign frameStart = tick && (digitIdx_q == 3'd7);

    always_comb begin
        presc_d    = presc_q + PW'(1);
        digitIdx_d = digitIdx_q;
        if (tick) begin
            presc_d    = '0;
            digitIdx_d = digitIdx_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q    <= '0;
            digitIdx_q <= 3'd0;
        end else begin
            presc_q    <= presc_d;
            digitIdx_q <= digitIdx_d;
        end
    end

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (frameStart),
        .bin   (syncCount),
        .done  (bcdDone),
        .bcd   (bcdValue)
    );

    // State and winner are captured with the count at frame start and held
    // until the conversion finishes, so all shown fields come from one sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            snapState_q  <= ST_IDLE;
            snapWinner_q <= WIN_NONE;
            dispState_q  <= ST_IDLE;
            dispWinner_q <= WIN_NONE;
            dispBcd_q    <= 12'd0;
        end else begin
            if (frameStart) begin
                snapState_q  <= syncState;
                snapWinner_q <= syncWinner;
            end
            if (bcdDone) begin
                dispState_q  <= snapState_q;
                dispWinner_q <= snapWinner_q;
                dispBcd_q    <= bcdValue;
            end
        end
    end

    // Glyph for the current digit slot from the committed display content.
    always_comb begin
        seg_d = G_BLANK;
        an_d  = ~(8'd1 << digitIdx_q);
        case (dispState_q)
            ST_IDLE: seg_d = G_DASH;
            ST_OPEN: begin
                case (digitIdx_q)
                    3'd7:    seg_d = G_O;
                    3'd6:    seg_d = G_P;
                    3'd5:    seg_d = G_E;
                    3'd4:    seg_d = G_N;
                    3'd2:    seg_d = digitGlyph(dispBcd_q[11:8]);
                    3'd1:    seg_d = digitGlyph(dispBcd_q[7:4]);
                    3'd0:    seg_d = digitGlyph(dispBcd_q[3:0]);
                    default: seg_d = G_BLANK;
                endcase
            end
            ST_CLOSED: begin
                case (digitIdx_q)
                    3'd7:    seg_d = G_C;
                    3'd6:    seg_d = G_L;
                    3'd5:    seg_d = G_O;
                    3'd4:    seg_d = G_S;
                    3'd3:    seg_d = G_E;
                    3'd2:    seg_d = G_D;
                    default: seg_d = G_BLANK;
                endcase
            end
            ST_WIN: begin
                case (digitIdx_q)
                    3'd7:    seg_d = (dispWinner_q == WIN_NONE) ? G_T : G_C;
                    3'd6:    seg_d = (dispWinner_q == WIN_NONE) ? G_I
                                     : digitGlyph({2'b00, dispWinner_q});
                    3'd5:    seg_d = (dispWinner_q == WIN_NONE) ? G_E : G_BLANK;
                    3'd2:    seg_d = digitGlyph(dispBcd_q[11:8]);
                    3'd1:    seg_d = digitGlyph(dispBcd_q[7:4]);
                    3'd0:    seg_d = digitGlyph(dispBcd_q[3:0]);
                    default: seg_d = G_BLANK;
                endcase
            end
            default: seg_d = G_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an_q  <= 8'hFF;
            seg_q <= 7'h7F;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    // Flasher arm condition, seen one flop early (armS1) so the rising edge
    // loads phase=1 exactly when the synchronized arm (armS2) goes high.
`ifdef VOTE_DISP_WINNER_LED_EN
    assign armS1 = sync1_q[0] | ((sync1_q[13:12] == ST_WIN) && (sync1_q[11:10] == WIN_NONE));
    assign armS2 = syncEn | ((syncState == ST_WIN) && (syncWinner == WIN_NONE));
`else
    assign armS1 = sync1_q[0];
    assign armS2 = syncEn;
`endif

    always_comb begin
        flashCnt_d = '0;
        phase_d    = 1'b0;
        if (armS1 && !armS2) begin
            phase_d = 1'b1;
        end else if (armS2) begin
            phase_d    = phase_q;
            flashCnt_d = flashCnt_q + FW'(1);
            if (flashCnt_q == FW'(FLASH_DIV - 1)) begin
                flashCnt_d = '0;
                phase_d    = ~phase_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flashCnt_q <= '0;
            phase_q    <= 1'b0;
        end else begin
            flashCnt_q <= flashCnt_d;
            phase_q    <= phase_d;
        end
    end

    // Gating with armS2 blanks the LEDs as soon as the arm drops.
`ifdef VOTE_DISP_WINNER_LED_EN
    always_comb begin
        led = {16{phase_q & armS2}};
        if (syncState == ST_WIN) begin
            if (syncWinner != WIN_NONE) begin
                led = 16'd1 << (syncWinner - 2'd1);
            end else begin
                led = {12'd0, {4{phase_q & armS2}}};
            end
        end
    end
`else
    assign led = {16{phase_q & armS2}};
`endif

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_vote_result_display.sv
// ---------------------------------------------------------------------------
// tb_vote_result_display
// Self-checking bench for vote_result_display with REFRESH_DIV=16 and
// FLASH_DIV=8. Cycle k is the k-th rising edge after reset release; a frame
// n spans edges 128n+1..128n+128, and digit i of frame n is sampled at the
// end of its slot (after edge 128n+16i+16). Honours VOTE_DISP_WINNER_LED_EN.
// ---------------------------------------------------------------------------
module tb_vote_result_display;

    localparam logic [6:0] G_0 = 7'h40, G_1 = 7'h79, G_2 = 7'h24, G_3 = 7'h30;
    localparam logic [6:0] G_5 = 7'h12, G_6 = 7'h02, G_7 = 7'h78, G_9 = 7'h10;
    localparam logic [6:0] G_DASH = 7'h3F, G_BL = 7'h7F;
    localparam logic [6:0] G_O = 7'h40, G_P = 7'h0C, G_E = 7'h06, G_N = 7'h2B;
    localparam logic [6:0] G_C = 7'h46, G_L = 7'h47, G_S = 7'h12, G_D = 7'h21;
    localparam logic [6:0] G_T = 7'h07, G_I = 7'h79;

    typedef struct {
        logic [1:0]  state;
        logic [1:0]  winner;
        logic [8:0]  count;
        logic [55:0] glyphs;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  the_state, the_winner;
    logic [8:0]  vote_count;
    logic        enable_leds;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] led;

    int cyc = 0;
    int checkCount = 0;
    int passCount = 0;
    vec_t vecs[8];

    vote_result_display #(.REFRESH_DIV(16), .FLASH_DIV(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .the_state   (the_state),
        .the_winner  (the_winner),
        .vote_count  (vote_count),
        .enable_leds (enable_leds),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .led         (led)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Edge counter since reset release.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Hard stop in case something stalls the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic [1:0] st, input logic [1:0] w,
                                 input logic [8:0] c, input logic en);
        the_state   = st;
        the_winner  = w;
        vote_count  = c;
        enable_leds = en;
    endtask

    // Advance to the falling edge after rising edge k.
    task automatic runTo(input int k);
        int guard = 0;
        while (cyc < k && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < k) begin
            checkCount++;
            $display("[TB] FAIL runTo: stuck at cycle %0d, wanted %0d", cyc, k);
        end
    endtask

    task automatic checkFrame(input int n, input logic [55:0] g, input string tag);
        logic [7:0] expAn;
        for (int i = 0; i < 8; i++) begin
            runTo(128*n + 16*i + 16);
            expAn = ~(8'd1 << i);
            checkOutput($sformatf("%s an d%0d", tag, i), {8'h00, an}, {8'h00, expAn});
            checkOutput($sformatf("%s seg d%0d", tag, i), {9'd0, seg}, {9'd0, g[7*i +: 7]});
            checkOutput($sformatf("%s dp d%0d", tag, i), {15'd0, dp}, 16'd1);
        end
    endtask

    initial begin
        int k0, f;
        vecs[0] = '{state: 2'b00, winner: 2'b00, count: 9'd0,   glyphs: {8{G_DASH}}};
        vecs[1] = '{state: 2'b01, winner: 2'b00, count: 9'd7,   glyphs: {G_O, G_P, G_E, G_N, G_BL, G_0, G_0, G_7}};
        vecs[2] = '{state: 2'b01, winner: 2'b00, count: 9'd511, glyphs: {G_O, G_P, G_E, G_N, G_BL, G_5, G_1, G_1}};
        vecs[3] = '{state: 2'b10, winner: 2'b00, count: 9'd511, glyphs: {G_C, G_L, G_O, G_S, G_E, G_D, G_BL, G_BL}};
        vecs[4] = '{state: 2'b11, winner: 2'b10, count: 9'd123, glyphs: {G_C, G_2, G_BL, G_BL, G_BL, G_1, G_2, G_3}};
        vecs[5] = '{state: 2'b11, winner: 2'b00, count: 9'd0,   glyphs: {G_T, G_I, G_E, G_BL, G_BL, G_0, G_0, G_0}};
        vecs[6] = '{state: 2'b11, winner: 2'b11, count: 9'd90,  glyphs: {G_C, G_3, G_BL, G_BL, G_BL, G_0, G_9, G_0}};
        vecs[7] = '{state: 2'b01, winner: 2'b00, count: 9'd256, glyphs: {G_O, G_P, G_E, G_N, G_BL, G_2, G_5, G_6}};

        reset = 1'b1;
        applyStimulus(2'b00, 2'b00, 9'd0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("reset an", {8'h00, an}, 16'h00FF);
        checkOutput("reset seg", {9'd0, seg}, 16'h007F);
        checkOutput("reset dp", {15'd0, dp}, 16'd1);
        checkOutput("reset led", led, 16'h0000);
        reset = 1'b0;

        runTo(1);
        checkOutput("first an", {8'h00, an}, 16'h00FE);
        checkOutput("first seg", {9'd0, seg}, {9'd0, G_DASH});

        // Each frame shows the vector applied during the previous frame;
        // the next vector is applied right after the commit, before any
        // digit of the current frame is sampled.
        for (int n = 0; n < 8; n++) begin
            if (n > 0) begin
                runTo(128*n + 10);
                checkOutput($sformatf("f%0d pre-commit d0", n), {9'd0, seg}, {9'd0, vecs[n-1].glyphs[6:0]});
                runTo(128*n + 11);
                checkOutput($sformatf("f%0d post-commit d0", n), {9'd0, seg}, {9'd0, vecs[n].glyphs[6:0]});
            end
            runTo(128*n + 11);
            if (n < 7) applyStimulus(vecs[n+1].state, vecs[n+1].winner, vecs[n+1].count, 1'b0);
            checkFrame(n, vecs[n].glyphs, $sformatf("f%0d", n));
        end

        // LED flasher: on 2 cycles after enable, 8-cycle half-period, off 2 cycles after disable.
        k0 = cyc;
        applyStimulus(2'b01, 2'b00, 9'd256, 1'b1);
        runTo(k0 + 1);  checkOutput("led k0+1", led, 16'h0000);
        runTo(k0 + 2);  checkOutput("led k0+2", led, 16'hFFFF);
        runTo(k0 + 9);  checkOutput("led k0+9", led, 16'hFFFF);
        runTo(k0 + 10); checkOutput("led k0+10", led, 16'h0000);
        runTo(k0 + 17); checkOutput("led k0+17", led, 16'h0000);
        runTo(k0 + 18); checkOutput("led k0+18", led, 16'hFFFF);
        runTo(k0 + 20);
        applyStimulus(2'b01, 2'b00, 9'd256, 1'b0);
        runTo(k0 + 21); checkOutput("led k0+21", led, 16'hFFFF);
        runTo(k0 + 22); checkOutput("led off k0+22", led, 16'h0000);
        runTo(k0 + 23); checkOutput("led off k0+23", led, 16'h0000);

        // Winner indication on LEDs in DISPLAY_WIN.
        k0 = cyc;
        applyStimulus(2'b11, 2'b10, 9'd123, 1'b0);
        runTo(k0 + 3);
`ifdef VOTE_DISP_WINNER_LED_EN
        checkOutput("win2 led", led, 16'h0002);
`else
        checkOutput("win2 led", led, 16'h0000);
`endif
        applyStimulus(2'b11, 2'b00, 9'd123, 1'b0);
        runTo(k0 + 5);
`ifdef VOTE_DISP_WINNER_LED_EN
        checkOutput("tie led on", led, 16'h000F);
`else
        checkOutput("tie led on", led, 16'h0000);
`endif
        runTo(k0 + 13);
        checkOutput("tie led off", led, 16'h0000);

        // Reset in the middle of a BCD conversion.
        applyStimulus(2'b01, 2'b00, 9'd511, 1'b1);
        f = (cyc / 128 + 1) * 128;
        runTo(f + 5);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midconv an", {8'h00, an}, 16'h00FF);
        checkOutput("midconv seg", {9'd0, seg}, 16'h007F);
        checkOutput("midconv dp", {15'd0, dp}, 16'd1);
        checkOutput("midconv led", led, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        runTo(1);
        checkOutput("rst2 an", {8'h00, an}, 16'h00FE);
        checkFrame(0, vecs[0].glyphs, "r0");
        checkFrame(1, vecs[2].glyphs, "r1");

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
